feature_arbiter: RTL and testbench

Merges detected features from NUM_LANES parallel detection lanes (each lane ends in an edge rejector) into one valid/ready feature stream for the downstream descriptor matcher. Detection lanes have no backpressure, so each lane gets a small FIFO. A round-robin scheduler drains the FIFOs into a single registered output slot. The block also enforces a per-frame feature budget and counts dropped features.

---
 rtl/feature_pkg.sv | 20 ++
 rtl/feature_arbiter_if.sv | 43 ++++
 rtl/feature_fifo.sv | 42 ++++
 rtl/feature_arbiter.sv | 145 ++++++++++++++
 tb/tb_feature_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/feature_pkg.sv
// Shared types for the feature arbiter: default payload widths, feature_t and the lane-index
// width helper.
package feature_pkg;

  localparam int unsigned DefaultBw   = 8;
  localparam int unsigned DefaultDw   = 128;
  localparam int unsigned DefaultIndW = 10;

  typedef struct packed {
    logic [DefaultBw-1:0]   strength;
    logic [DefaultDw-1:0]   descriptor;
    logic [DefaultIndW-1:0] x;
    logic [DefaultIndW-1:0] y;
  } feature_t;

  function automatic int unsigned lane_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_arbiter_if.sv
// Lane-side inputs, output feature stream and frame counters of the feature arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface feature_arbiter_if import feature_pkg::*; #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned BW        = DefaultBw,
  parameter int unsigned DW        = DefaultDw,
  parameter int unsigned IND_W     = DefaultIndW,
  parameter int unsigned CNT_W     = 16
) ();
  localparam int unsigned LW = lane_w(NUM_LANES);

  logic                       frame_start;
  logic [NUM_LANES-1:0]       lane_detected;
  logic [NUM_LANES*BW-1:0]    lane_strength;
  logic [NUM_LANES*DW-1:0]    lane_descriptor;
  logic [NUM_LANES*IND_W-1:0] lane_x;
  logic [NUM_LANES*IND_W-1:0] lane_y;

  logic                       out_valid;
  logic                       out_ready;
  logic [LW-1:0]              out_lane;
  logic [BW-1:0]              out_strength;
  logic [DW-1:0]              out_descriptor;
  logic [IND_W-1:0]           out_x;
  logic [IND_W-1:0]           out_y;

  logic [CNT_W-1:0]           frame_count;
  logic [CNT_W-1:0]           drop_count;
  logic                       cap_hit;

  modport slave (
    input  frame_start, lane_detected, lane_strength, lane_descriptor, lane_x, lane_y, out_ready,
    output out_valid, out_lane, out_strength, out_descriptor, out_x, out_y,
    output frame_count, drop_count, cap_hit
  );

  modport master (
    output frame_start, lane_detected, lane_strength, lane_descriptor, lane_x, lane_y, out_ready,
    input  out_valid, out_lane, out_strength, out_descriptor, out_x, out_y,
    input  frame_count, drop_count, cap_hit
  );

endinterface

// File: rtl/feature_fifo.sv
// Per-lane synchronous FIFO with asynchronous active-high reset. A push while full is
// accepted only when a pop happens in the same cycle.
module feature_fifo import feature_pkg::*; #(
  parameter int unsigned DEPTH  = 4,
  parameter type         item_t = feature_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  item_t data_i,
  input  logic  pop_i,
  output item_t data_o,
  output logic  full_o,
  output logic  empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  item_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/feature_arbiter.sv
// Round-robin merge of per-lane feature FIFOs into one registered valid/ready slot, with frame
// and drop counters. Define FEATURE_CAP_EN to enforce the MAX_FEATURES per-frame budget.
module feature_arbiter import feature_pkg::*; #(
  parameter int unsigned NUM_LANES    = 2,
  parameter int unsigned LANE_DEPTH   = 4,
  parameter int unsigned BW           = DefaultBw,
  parameter int unsigned DW           = DefaultDw,
  parameter int unsigned IND_W        = DefaultIndW,
  parameter int unsigned MAX_FEATURES = 256,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  feature_arbiter_if.slave  feat_io
);
  localparam int unsigned      LW       = lane_w(NUM_LANES);
  localparam logic [CNT_W-1:0] MaxCount = CNT_W'(MAX_FEATURES);
`ifdef FEATURE_CAP_EN
  localparam bit CapEn = 1'b1;
`else
  localparam bit CapEn = 1'b0;
`endif

  typedef struct packed {
    logic [BW-1:0]    strength;
    logic [DW-1:0]    descriptor;
    logic [IND_W-1:0] x;
    logic [IND_W-1:0] y;
  } lane_feat_t;

  lane_feat_t           push_data [NUM_LANES];
  lane_feat_t           pop_data  [NUM_LANES];
  logic [NUM_LANES-1:0] full, empty, pop, drop_lane;

  logic             out_valid_q, out_valid_d;
  logic [LW-1:0]    out_lane_q;
  lane_feat_t       out_feat_q;
  logic [LW-1:0]    last_grant_q, grant_idx;
  logic [CNT_W-1:0] frame_count_q, frame_count_d, fc_base;
  logic [CNT_W-1:0] drop_count_q, drop_count_d, dc_base;
  logic [CNT_W:0]   n_drop, drop_sum;
  logic             cap_hit_q, cap_hit_d;
  logic             slot_free, grant_valid, capped, load, cap_drop;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign push_data[g] = '{
      strength:   feat_io.lane_strength[g*BW +: BW],
      descriptor: feat_io.lane_descriptor[g*DW +: DW],
      x:          feat_io.lane_x[g*IND_W +: IND_W],
      y:          feat_io.lane_y[g*IND_W +: IND_W]
    };
    // Full FIFO with a same-cycle pop still accepts the push, so that is not a drop.
    assign drop_lane[g] = feat_io.lane_detected[g] && full[g] && !pop[g];

    feature_fifo #(
      .DEPTH  (LANE_DEPTH),
      .item_t (lane_feat_t)
    ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (feat_io.lane_detected[g]),
      .data_i  (push_data[g]),
      .pop_i   (pop[g]),
      .data_o  (pop_data[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  assign slot_free = !out_valid_q || feat_io.out_ready;

  always_comb begin
    int unsigned idx;
    logic        found;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_LANES; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_LANES;
      if (!found && !empty[idx]) begin
        found     = 1'b1;
        grant_idx = LW'(idx);
      end
    end
    grant_valid = found && slot_free;
    pop = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  // Once the budget is reached, granted features are still popped but discarded.
  assign capped   = CapEn && (frame_count_q == MaxCount);
  assign load     = grant_valid && !capped;
  assign cap_drop = grant_valid && capped;

  always_comb begin
    out_valid_d = slot_free ? load : out_valid_q;

    fc_base       = feat_io.frame_start ? '0 : frame_count_q;
    frame_count_d = fc_base;
    if (load && (fc_base != '1)) frame_count_d = fc_base + 1'b1;

    n_drop = (CNT_W+1)'(cap_drop);
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      n_drop = n_drop + (CNT_W+1)'(drop_lane[i]);
    end
    dc_base      = feat_io.frame_start ? '0 : drop_count_q;
    drop_sum     = {1'b0, dc_base} + n_drop;
    drop_count_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    cap_hit_d = CapEn && (frame_count_d == MaxCount);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_lane_q    <= '0;
      out_feat_q    <= '0;
      last_grant_q  <= LW'(NUM_LANES - 1);
      frame_count_q <= '0;
      drop_count_q  <= '0;
      cap_hit_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        out_lane_q <= grant_idx;
        out_feat_q <= pop_data[grant_idx];
      end
      if (grant_valid) last_grant_q <= grant_idx;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      cap_hit_q     <= cap_hit_d;
    end
  end

  assign feat_io.out_valid      = out_valid_q;
  assign feat_io.out_lane       = out_lane_q;
  assign feat_io.out_strength   = out_feat_q.strength;
  assign feat_io.out_descriptor = out_feat_q.descriptor;
  assign feat_io.out_x          = out_feat_q.x;
  assign feat_io.out_y          = out_feat_q.y;
  assign feat_io.frame_count    = frame_count_q;
  assign feat_io.drop_count     = drop_count_q;
  assign feat_io.cap_hit        = cap_hit_q;

endmodule

// File: tb/tb_feature_arbiter.sv
// Self-checking bench for feature_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_feature_arbiter;
  import feature_pkg::*;

  localparam int unsigned NL = 2, DEPTH = 4, BW = 8, DW = 128, IW = 10, MAXF = 3, CW = 16;
  localparam longint CntMax = (64'd1 << CW) - 1;
`ifdef FEATURE_CAP_EN
  localparam bit CapEn = 1'b1;
`else
  localparam bit CapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  feature_arbiter_if #(.NUM_LANES(NL), .BW(BW), .DW(DW), .IND_W(IW), .CNT_W(CW)) intf ();

  feature_arbiter #(
    .NUM_LANES    (NL),
    .LANE_DEPTH   (DEPTH),
    .BW           (BW),
    .DW           (DW),
    .IND_W        (IW),
    .MAX_FEATURES (MAXF),
    .CNT_W        (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .feat_io (intf)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic feature_t lane_in(input int i);
    feature_t f;
    f.strength   = intf.lane_strength[i*BW +: BW];
    f.descriptor = intf.lane_descriptor[i*DW +: DW];
    f.x          = intf.lane_x[i*IW +: IW];
    f.y          = intf.lane_y[i*IW +: IW];
    return f;
  endfunction

  function automatic feature_t rand_feat();
    feature_t f;
    f.strength   = 8'($urandom);
    f.descriptor = {$urandom, $urandom, $urandom, $urandom};
    f.x          = 10'($urandom);
    f.y          = 10'($urandom);
    return f;
  endfunction

  task automatic drive_lane(input int i, input bit det, input feature_t f);
    intf.lane_detected[i]          = det;
    intf.lane_strength[i*BW +: BW]   = f.strength;
    intf.lane_descriptor[i*DW +: DW] = f.descriptor;
    intf.lane_x[i*IW +: IW]          = f.x;
    intf.lane_y[i*IW +: IW]          = f.y;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Behavioural model: one queue per lane, a slot, and plain counters.
  feature_t mq [NL][$];
  bit       m_valid;
  int       m_lane, m_last;
  feature_t m_feat;
  longint   m_fc, m_dc;
  bit       m_cap;

  always @(posedge clk or posedge rst) begin
    int       g, l;
    bit       free, capped;
    longint   drops, fcb;
    feature_t f;
    if (rst) begin
      for (int i = 0; i < NL; i++) mq[i].delete();
      m_valid = 0; m_lane = 0; m_feat = '0; m_last = NL - 1;
      m_fc = 0; m_dc = 0; m_cap = 0;
    end else begin
      free = !m_valid || intf.out_ready;
      g = -1;
      if (free) begin
        for (int k = 1; k <= NL; k++) begin
          l = (m_last + k) % NL;
          if (g < 0 && mq[l].size() > 0) g = l;
        end
      end
      drops  = 0;
      fcb    = intf.frame_start ? 0 : m_fc;
      capped = CapEn && (m_fc == MAXF);
      if (g >= 0) begin
        f = mq[g].pop_front();
        m_last = g;
        if (capped) begin
          drops++;
          m_valid = 0;
        end else begin
          m_valid = 1; m_lane = g; m_feat = f;
          if (fcb < CntMax) fcb++;
        end
      end else if (free) begin
        m_valid = 0;
      end
      for (int i = 0; i < NL; i++) begin
        if (intf.lane_detected[i]) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(lane_in(i));
          else drops++;
        end
      end
      m_dc  = (intf.frame_start ? 0 : m_dc) + drops;
      if (m_dc > CntMax) m_dc = CntMax;
      m_fc  = fcb;
      m_cap = CapEn && (m_fc == MAXF);
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("m_valid", intf.out_valid, m_valid);
      if (m_valid) begin
        chk("m_lane", intf.out_lane, m_lane);
        chk("m_strength", intf.out_strength, m_feat.strength);
        chk("m_descriptor", intf.out_descriptor, m_feat.descriptor);
        chk("m_xy", {intf.out_x, intf.out_y}, {m_feat.x, m_feat.y});
      end
      chk("m_frame_count", intf.frame_count, m_fc);
      chk("m_drop_count", intf.drop_count, m_dc);
      chk("m_cap_hit", intf.cap_hit, m_cap);
    end
  end

  task automatic idle_inputs();
    intf.frame_start = 0;
    for (int i = 0; i < NL; i++) drive_lane(i, 0, '0);
  endtask

  int       lanes_q[$];
  feature_t feats_q[$];
  feature_t a [6];
  feature_t f1;

  initial begin
    intf.out_ready = 0;
    idle_inputs();
    repeat (2) cyc();
    chk("rst_valid", intf.out_valid, 0);
    chk("rst_lane", intf.out_lane, 0);
    chk("rst_payload", {intf.out_strength, intf.out_descriptor, intf.out_x, intf.out_y}, 0);
    chk("rst_frame_count", intf.frame_count, 0);
    chk("rst_drop_count", intf.drop_count, 0);
    chk("rst_cap_hit", intf.cap_hit, 0);
    rst = 0;
    chk_en = 1;
    cyc();

    // Single feature on lane 1.
    f1 = '0; f1.x = 7; f1.y = 9; f1.strength = 8'h40;
    intf.out_ready = 1;
    drive_lane(1, 1, f1);
    cyc();
    drive_lane(1, 0, '0);
    chk("single_not_yet", intf.out_valid, 0);
    cyc();
    chk("single_valid", intf.out_valid, 1);
    chk("single_lane", intf.out_lane, 1);
    chk("single_x", intf.out_x, 7);
    chk("single_y", intf.out_y, 9);
    chk("single_strength", intf.out_strength, 8'h40);
    chk("single_fc", intf.frame_count, 1);
    cyc();
    chk("single_accepted", intf.out_valid, 0);

    // Round-robin with both lanes detecting for 4 cycles.
    lanes_q.delete();
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < NL; i++) drive_lane(i, c < 4, rand_feat());
      cyc();
      if (intf.out_valid) lanes_q.push_back(int'(intf.out_lane));
    end
    chk("rr_count", lanes_q.size(), CapEn ? 2 : 8);
    foreach (lanes_q[j]) chk("rr_alternate", lanes_q[j], j % 2);
    chk("rr_drops", intf.drop_count, CapEn ? 6 : 0);

    // Backpressure and overflow on lane 0.
    intf.frame_start = 1;
    cyc();
    intf.frame_start = 0;
    intf.out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      a[c] = rand_feat();
      a[c].x = 10'(100 + c);
      drive_lane(0, 1, a[c]);
      cyc();
    end
    drive_lane(0, 0, '0);
    chk("bp_drop_count", intf.drop_count, 1);
    chk("bp_valid", intf.out_valid, 1);
    chk("bp_x", intf.out_x, a[0].x);
    chk("bp_descriptor", intf.out_descriptor, a[0].descriptor);
    repeat (2) cyc();
    chk("bp_stable_x", intf.out_x, a[0].x);
    chk("bp_stable_descriptor", intf.out_descriptor, a[0].descriptor);
    intf.out_ready = 1;
    feats_q.delete();
    for (int c = 0; c < 10; c++) begin
      if (intf.out_valid) begin
        f1 = '0; f1.x = intf.out_x; f1.descriptor = intf.out_descriptor;
        feats_q.push_back(f1);
      end
      cyc();
    end
    chk("bp_drain_count", feats_q.size(), CapEn ? 3 : 5);
    foreach (feats_q[j]) chk("bp_drain_order", {feats_q[j].x, feats_q[j].descriptor},
                             {a[j].x, a[j].descriptor});

    // frame_start coinciding with a load.
    chk("fs_pre_fc", intf.frame_count, CapEn ? 3 : 5);
    drive_lane(0, 1, rand_feat());
    cyc();
    drive_lane(0, 0, '0);
    intf.frame_start = 1;
    cyc();
    intf.frame_start = 0;
    chk("fs_fc", intf.frame_count, CapEn ? 0 : 1);
    chk("fs_dc", intf.drop_count, CapEn ? 1 : 0);
    chk("fs_valid", intf.out_valid, CapEn ? 0 : 1);
    repeat (3) cyc();

`ifdef FEATURE_CAP_EN
    // Budget: 5 detections against MAX_FEATURES=3.
    intf.frame_start = 1;
    cyc();
    intf.frame_start = 0;
    lanes_q.delete();
    for (int c = 0; c < 12; c++) begin
      drive_lane(0, c < 5, rand_feat());
      cyc();
      if (intf.out_valid) lanes_q.push_back(int'(intf.out_lane));
    end
    chk("cap_emitted", lanes_q.size(), 3);
    chk("cap_hit", intf.cap_hit, 1);
    chk("cap_drops", intf.drop_count, 2);
    chk("cap_fc", intf.frame_count, 3);
    intf.frame_start = 1;
    cyc();
    intf.frame_start = 0;
    chk("cap_cleared", intf.cap_hit, 0);
    chk("cap_fc_cleared", intf.frame_count, 0);
`endif

    // Asynchronous reset mid-transfer.
    intf.out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NL; i++) drive_lane(i, 1, rand_feat());
      cyc();
    end
    idle_inputs();
    chk("ar_pre_valid", intf.out_valid, 1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("ar_valid_async", intf.out_valid, 0);
    chk("ar_fc_async", intf.frame_count, 0);
    repeat (2) cyc();
    rst = 0;
    intf.out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("ar_fifos_empty", intf.out_valid, 0);
    end
    for (int i = 0; i < NL; i++) drive_lane(i, 1, rand_feat());
    cyc();
    idle_inputs();
    cyc();
    chk("ar_first_lane0", {intf.out_valid, intf.out_lane}, {1'b1, 1'b0});
    cyc();
    chk("ar_second_lane1", {intf.out_valid, intf.out_lane}, {1'b1, 1'b1});
    repeat (3) cyc();

    // Randomized traffic with phases of varying backpressure.
    for (int c = 0; c < 3000; c++) begin
      int rdy_pct;
      rdy_pct = ((c / 300) % 3 == 0) ? 20 : (((c / 300) % 3 == 1) ? 60 : 95);
      for (int i = 0; i < NL; i++) drive_lane(i, $urandom_range(0, 99) < 45, rand_feat());
      intf.out_ready   = $urandom_range(0, 99) < rdy_pct;
      intf.frame_start = $urandom_range(0, 39) == 0;
      cyc();
    end
    idle_inputs();
    intf.out_ready = 1;
    repeat (20) cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
